// File: rtl/cpc_input_pkg.sv
// Shared types and constants for the CPC host-input blocks (joystick / AMX mouse arbitration).
package cpc_input_pkg;

  typedef enum logic [1:0] {
    JOY    = 2'd0,
    MOUSE  = 2'd1,
    PEND_M = 2'd2,
    PEND_J = 2'd3
  } arb_state_t;

  localparam logic [1:0] ARB_AUTO  = 2'd0;
  localparam logic [1:0] ARB_JOY   = 2'd1;
  localparam logic [1:0] ARB_MOUSE = 2'd2;

  // Row bit fields: [6:4] fire3..1, [3:0] R/L/D/U
  localparam int FIRE_MSB = 6;
  localparam int FIRE_LSB = 4;
  localparam int DIR_MSB  = 3;
  localparam int DIR_LSB  = 0;

  // Host mouse packet fields
  localparam int PKT_STB    = 24;
  localparam int PKT_DY_MSB = 23;
  localparam int PKT_DY_LSB = 16;
  localparam int PKT_DX_MSB = 15;
  localparam int PKT_DX_LSB = 8;
  localparam int PKT_BT_MSB = 2;
  localparam int PKT_BT_LSB = 0;

endpackage

// File: rtl/arb_idle_timer.sv
// Saturating idle counter: counts enabled cycles, sticks at IDLE_CYCLES-1 and flags expiry there.
module arb_idle_timer #(
  parameter int unsigned IDLE_CYCLES = 24'd8_000_000,
  parameter int          CW          = 24
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [CW-1:0] LAST = CW'(IDLE_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)                cnt <= '0;
    else if (clr)                cnt <= '0;
    else if (en && cnt != LAST)  cnt <= cnt + 1'b1;
  end

  assign expired = (cnt == LAST);

endmodule

// File: rtl/mouse_joy_arbiter.sv
// Joystick-0 row arbiter between host joystick and AMX mouse converter; owner swaps only on a sel fall.
// Optional: MOUSE_ARB_MERGE_EN keeps joystick fire buttons live while the mouse owns the row.
module mouse_joy_arbiter
  import cpc_input_pkg::*;
#(
  parameter int unsigned IDLE_CYCLES = 24'd8_000_000,
  parameter int          CW          = 24
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [1:0]  mode,
  input  logic [24:0] ps2_mouse,
  input  logic [6:0]  joy,
  input  logic [6:0]  mouse_din,
  input  logic        sel,
  output logic [6:0]  dout,
  output logic        owner,
  output logic        mouse_rst
);

  arb_state_t state, state_nx;
  logic       sel_q, stb_q, hist_vld;
  logic       mouse_act, joy_act, boundary, auto_md, expired;
  logic       owner_nx;
  logic [6:0] dout_nx;
  logic       unused_pkt;

  assign unused_pkt = &{1'b0, ps2_mouse[7:3]};

  // hist_vld masks the first cycle after reset so a stale strobe level is not seen as a packet
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sel_q    <= 1'b0;
      stb_q    <= 1'b0;
      hist_vld <= 1'b0;
    end else begin
      sel_q    <= sel;
      stb_q    <= ps2_mouse[PKT_STB];
      hist_vld <= 1'b1;
    end
  end

  assign mouse_act = hist_vld && (ps2_mouse[PKT_STB] != stb_q) &&
                     ((|ps2_mouse[PKT_DX_MSB:PKT_DX_LSB]) ||
                      (|ps2_mouse[PKT_DY_MSB:PKT_DY_LSB]) ||
                      (|ps2_mouse[PKT_BT_MSB:PKT_BT_LSB]));
`ifdef MOUSE_ARB_MERGE_EN
  assign joy_act   = |joy[DIR_MSB:DIR_LSB];
`else
  assign joy_act   = |joy;
`endif
  assign boundary  = sel_q && !sel;
  assign auto_md   = (mode == ARB_AUTO) || (mode == 2'd3);

  arb_idle_timer #(.IDLE_CYCLES(IDLE_CYCLES), .CW(CW)) u_idle (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .clr     (mouse_act || state != MOUSE),
    .en      (auto_md && state == MOUSE),
    .expired (expired)
  );

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= JOY;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (mode == ARB_JOY) begin
      if (boundary) state_nx = JOY;
    end else if (mode == ARB_MOUSE) begin
      if (boundary) state_nx = MOUSE;
    end else begin
      // joystick wins every same-cycle conflict
      unique case (state)
        JOY:    if (mouse_act && !joy_act) state_nx = PEND_M;
        PEND_M: if (joy_act)               state_nx = JOY;
                else if (boundary)         state_nx = MOUSE;
        MOUSE:  if (joy_act || (expired && !mouse_act)) state_nx = PEND_J;
        PEND_J: if (boundary)              state_nx = JOY;
                else if (mouse_act && !joy_act) state_nx = MOUSE;
        default: state_nx = JOY;
      endcase
    end
  end

  // Outputs are registered from next state so owner, mouse_rst and dout all switch on one edge
  always_comb begin
    owner_nx = (state_nx == MOUSE) || (state_nx == PEND_J);
    dout_nx  = owner_nx ? mouse_din : joy;
`ifdef MOUSE_ARB_MERGE_EN
    dout_nx[FIRE_MSB:FIRE_LSB] = dout_nx[FIRE_MSB:FIRE_LSB] | joy[FIRE_MSB:FIRE_LSB];
`endif
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dout      <= '0;
      owner     <= 1'b0;
      mouse_rst <= 1'b1;
    end else begin
      dout      <= dout_nx;
      owner     <= owner_nx;
      mouse_rst <= !owner_nx;
    end
  end

endmodule

// File: tb/tb_mouse_joy_arbiter.sv
// Directed bench for mouse_joy_arbiter with a 16-cycle idle timeout.
module tb_mouse_joy_arbiter;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic [1:0]  mode;
  logic [24:0] ps2_mouse;
  logic [6:0]  joy;
  logic [6:0]  mouse_din;
  logic        sel;
  logic [6:0]  dout;
  logic        owner;
  logic        mouse_rst;

  int checks = 0;
  int errors = 0;

  always #5 clk_sys = ~clk_sys;

  mouse_joy_arbiter #(.IDLE_CYCLES(24'd16), .CW(24)) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .mode      (mode),
    .ps2_mouse (ps2_mouse),
    .joy       (joy),
    .mouse_din (mouse_din),
    .sel       (sel),
    .dout      (dout),
    .owner     (owner),
    .mouse_rst (mouse_rst)
  );

  task automatic tick;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic send_pkt(input logic [7:0] dx, input logic [7:0] dy, input logic [2:0] bt);
    ps2_mouse = {~ps2_mouse[24], dy, dx, 5'b0, bt};
    tick;
  endtask

  task automatic pulse_boundary;
    sel = 1'b1;
    tick;
    sel = 1'b0;
    tick;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; mode = 2'd0; joy = 7'h00; sel = 1'b0; mouse_din = 7'h2A;
    ps2_mouse = {1'b1, 8'h00, 8'h05, 5'b0, 3'b000};
    repeat (3) tick;
    checks++; if (dout !== 7'h00)   begin errors++; $display("FAIL reset_dout got %h want %h", dout, 7'h00); end
    checks++; if (owner !== 1'b0)   begin errors++; $display("FAIL reset_owner got %b want 0", owner); end
    checks++; if (mouse_rst !== 1'b1) begin errors++; $display("FAIL reset_mouse_rst got %b want 1", mouse_rst); end
    reset_n = 1'b1;
    tick;
    pulse_boundary;
    checks++; if (owner !== 1'b0)   begin errors++; $display("FAIL first_strobe_owner got %b want 0", owner); end
    checks++; if (mouse_rst !== 1'b1) begin errors++; $display("FAIL first_strobe_rst got %b want 1", mouse_rst); end
  endtask

  task automatic test_takeover;
    send_pkt(8'd8, 8'd0, 3'b000);
    repeat (3) tick;
    checks++; if (owner !== 1'b0)   begin errors++; $display("FAIL pend_owner got %b want 0", owner); end
    sel = 1'b1;
    tick;
    checks++; if (owner !== 1'b0)   begin errors++; $display("FAIL pre_edge_owner got %b want 0", owner); end
    checks++; if (mouse_rst !== 1'b1) begin errors++; $display("FAIL pre_edge_rst got %b want 1", mouse_rst); end
    sel = 1'b0;
    tick;
    checks++; if (owner !== 1'b1)   begin errors++; $display("FAIL take_owner got %b want 1", owner); end
    checks++; if (mouse_rst !== 1'b0) begin errors++; $display("FAIL take_rst got %b want 0", mouse_rst); end
    checks++; if (dout !== 7'h2A)   begin errors++; $display("FAIL take_dout got %h want %h", dout, 7'h2A); end
    mouse_din = 7'h15;
    tick;
    checks++; if (dout !== 7'h15)   begin errors++; $display("FAIL mouse_follow got %h want %h", dout, 7'h15); end
  endtask

  task automatic test_idle_timeout;
    send_pkt(8'd0, 8'd3, 3'b000);
    repeat (13) tick;
    sel = 1'b1;
    tick;
    sel = 1'b0;
    tick;
    checks++; if (owner !== 1'b1)   begin errors++; $display("FAIL idle_early got %b want 1", owner); end
    sel = 1'b1;
    tick;
    checks++; if (owner !== 1'b1)   begin errors++; $display("FAIL idle_pend_owner got %b want 1", owner); end
    sel = 1'b0;
    tick;
    checks++; if (owner !== 1'b0)   begin errors++; $display("FAIL idle_owner got %b want 0", owner); end
    checks++; if (mouse_rst !== 1'b1) begin errors++; $display("FAIL idle_rst got %b want 1", mouse_rst); end
    checks++; if (dout !== 7'h00)   begin errors++; $display("FAIL idle_dout got %h want %h", dout, 7'h00); end
  endtask

  task automatic test_mouse_resumes;
    send_pkt(8'd1, 8'd0, 3'b000);
    pulse_boundary;
    checks++; if (owner !== 1'b1)   begin errors++; $display("FAIL resume_setup got %b want 1", owner); end
    joy = 7'h02;
    tick;
    joy = 7'h00;
    checks++; if (owner !== 1'b1)   begin errors++; $display("FAIL pend_j_owner got %b want 1", owner); end
    send_pkt(8'd2, 8'd0, 3'b000);
    pulse_boundary;
    checks++; if (owner !== 1'b1)   begin errors++; $display("FAIL resume_owner got %b want 1", owner); end
  endtask

  task automatic test_merge;
    mouse_din = 7'h00;
    joy = 7'h10;
    tick;
`ifdef MOUSE_ARB_MERGE_EN
    checks++; if (dout !== 7'h10)   begin errors++; $display("FAIL merge_dout got %h want %h", dout, 7'h10); end
`else
    checks++; if (dout !== 7'h00)   begin errors++; $display("FAIL nomerge_dout got %h want %h", dout, 7'h00); end
`endif
    joy = 7'h00;
    pulse_boundary;
`ifdef MOUSE_ARB_MERGE_EN
    checks++; if (owner !== 1'b1)   begin errors++; $display("FAIL merge_owner got %b want 1", owner); end
`else
    checks++; if (owner !== 1'b0)   begin errors++; $display("FAIL nomerge_owner got %b want 0", owner); end
`endif
    joy = 7'h01;
    tick;
    joy = 7'h00;
    pulse_boundary;
    checks++; if (owner !== 1'b0)   begin errors++; $display("FAIL back_to_joy got %b want 0", owner); end
  endtask

  task automatic test_conflict;
    joy = 7'h01;
    send_pkt(8'd8, 8'd0, 3'b000);
    checks++; if (dout !== 7'h01)   begin errors++; $display("FAIL conflict_dout got %h want %h", dout, 7'h01); end
    joy = 7'h00;
    pulse_boundary;
    checks++; if (owner !== 1'b0)   begin errors++; $display("FAIL conflict_owner got %b want 0", owner); end
    joy = 7'h0C;
    tick;
    checks++; if (dout !== 7'h0C)   begin errors++; $display("FAIL joy_dout got %h want %h", dout, 7'h0C); end
    joy = 7'h00;
    send_pkt(8'd0, 8'd0, 3'b000);
    pulse_boundary;
    checks++; if (owner !== 1'b0)   begin errors++; $display("FAIL empty_pkt_owner got %b want 0", owner); end
    send_pkt(8'd0, 8'd0, 3'b001);
    pulse_boundary;
    checks++; if (owner !== 1'b1)   begin errors++; $display("FAIL button_pkt_owner got %b want 1", owner); end
    joy = 7'h01;
    tick;
    joy = 7'h00;
    pulse_boundary;
    checks++; if (owner !== 1'b0)   begin errors++; $display("FAIL conflict_exit got %b want 0", owner); end
  endtask

  task automatic test_forced;
    mode = 2'd2;
    tick;
    checks++; if (owner !== 1'b0)   begin errors++; $display("FAIL force_m_wait got %b want 0", owner); end
    pulse_boundary;
    checks++; if (owner !== 1'b1)   begin errors++; $display("FAIL force_m_owner got %b want 1", owner); end
    checks++; if (mouse_rst !== 1'b0) begin errors++; $display("FAIL force_m_rst got %b want 0", mouse_rst); end
    repeat (20) tick;
    pulse_boundary;
    checks++; if (owner !== 1'b1)   begin errors++; $display("FAIL force_m_no_idle got %b want 1", owner); end
    mode = 2'd1;
    tick;
    checks++; if (owner !== 1'b1)   begin errors++; $display("FAIL force_j_wait got %b want 1", owner); end
    pulse_boundary;
    checks++; if (owner !== 1'b0)   begin errors++; $display("FAIL force_j_owner got %b want 0", owner); end
    send_pkt(8'd4, 8'd4, 3'b000);
    pulse_boundary;
    checks++; if (owner !== 1'b0)   begin errors++; $display("FAIL force_j_hold got %b want 0", owner); end
    mode = 2'd3;
    send_pkt(8'd4, 8'd0, 3'b000);
    pulse_boundary;
    checks++; if (owner !== 1'b1)   begin errors++; $display("FAIL mode3_auto got %b want 1", owner); end
    mode = 2'd0;
  endtask

  task automatic test_reset_mid_switch;
    joy = 7'h04;
    tick;
    joy = 7'h00;
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (owner !== 1'b0)   begin errors++; $display("FAIL async_owner got %b want 0", owner); end
    checks++; if (dout !== 7'h00)   begin errors++; $display("FAIL async_dout got %h want %h", dout, 7'h00); end
    checks++; if (mouse_rst !== 1'b1) begin errors++; $display("FAIL async_rst got %b want 1", mouse_rst); end
    tick;
    tick;
    reset_n = 1'b1;
    tick;
    pulse_boundary;
    checks++; if (owner !== 1'b0)   begin errors++; $display("FAIL abandon_pend got %b want 0", owner); end
  endtask

  initial begin
    test_reset;
    test_takeover;
    test_idle_timeout;
    test_mouse_resumes;
    test_merge;
    test_conflict;
    test_forced;
    test_reset_mid_switch;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mouse_joy_arbiter.md
# mouse_joy_arbiter

Shares the CPC joystick-0 matrix row between the host joystick and the emulated AMX mouse converter. It selects one owner, switches owners only at a row-scan boundary so the CPU never reads a mixed row, and holds the mouse converter in reset while the joystick owns the port. It sits between the joystick/mouse sources and the keyboard matrix row mux.

## Interface

**Parameters**
- `IDLE_CYCLES`, default 24'd8_000_000: clk_sys cycles without mouse activity before ownership returns to the joystick.
- `CW`, default 24: width of the idle counter.

**Ports.** Clock and reset: one clock; reset is asynchronous and active-low.
- `clk_sys`  in  1  system clock.
- `reset_n`  in  1  asynchronous active-low reset.
- `mode`  in  2  0 = auto, 1 = joystick forced, 2 = mouse forced, 3 = treated as 0.
- `ps2_mouse`  in  25  host mouse packet: [24] toggle strobe, [23:16] dy, [15:8] dx, [2:0] buttons.
- `joy`  in  7  host joystick, active-high: [6:4] fire3..1, [3:0] R/L/D/U.
- `mouse_din`  in  7  row bits from the mouse converter.
- `sel`  in  1  row-select from the matrix scanner.
- `dout`  out  7  arbitrated row bits, registered.
- `owner`  out  1  0 = joystick, 1 = mouse.
- `mouse_rst`  out  1  active-high reset to the mouse converter.

## Operation

**Events**
- *Mouse activity*: `ps2_mouse[24]` differs from its 1-cycle-delayed copy AND (dx≠0 OR dy≠0 OR buttons≠0).
- *Joystick activity*: `joy` ≠ 0.
- *Boundary*: falling edge of `sel` (registered `sel` = 1, current `sel` = 0).

**FSM** — states JOY, MOUSE, PEND_M, PEND_J. Transitions in auto mode:
- JOY → PEND_M on mouse activity with no joystick activity in the same cycle.
- PEND_M → MOUSE on boundary.
- PEND_M → JOY if joystick activity occurs before the boundary.
- MOUSE → PEND_J on joystick activity, or when the idle counter reaches `IDLE_CYCLES`-1.
- PEND_J → JOY on boundary.
- PEND_J → MOUSE on mouse activity before the boundary, unless joystick activity is also present.
- Joystick wins every simultaneous conflict.

**Forced modes**
- Mode 1: the next boundary drives the FSM to JOY, and it stays there.
- Mode 2: the next boundary drives it to MOUSE, and it stays there.
- The idle counter is inert in both.
- A mode change is sampled every cycle; leaving a forced mode resumes auto from the current state.

**Idle counter**
- Cleared on mouse activity and in every state except MOUSE.
- Increments in MOUSE and saturates at `IDLE_CYCLES`-1.

**Outputs**
- `owner` = 1 in MOUSE and PEND_J, 0 in JOY and PEND_M. The old owner is kept while a switch is pending.
- `dout` = `mouse_din` when `owner` = 1, else `joy`.
- `mouse_rst` = 1 in JOY and PEND_M, so the converter accumulates nothing while not owner.

## Timing

- All outputs are registered; latency from input to `dout` is 1 clk_sys.
- Reset values: state JOY, `dout` = 0, `owner` = 0, `mouse_rst` = 1, idle counter 0, `sel` and strobe history 0.
- An ownership change becomes visible on `dout` on the cycle after the boundary edge.
- `mouse_rst` deasserts in the same cycle that `owner` goes to 1. The converter therefore starts from zero accumulation, and the triggering packet is lost by design.
- Reset asserted mid-switch abandons the pending state immediately.
- The first strobe after reset release is not counted as activity: the strobe history is loaded from `ps2_mouse[24]` on the first cycle.

## Configuration

- `MOUSE_ARB_MERGE_EN` defined: `dout[6:4]` = the owner's bits OR `joy[6:4]`, so the joystick fire buttons stay live while the mouse owns the port. A press of fire alone does not count as joystick activity; only `joy[3:0]` ≠ 0 does.
- Undefined: `dout` carries pure owner bits, and any `joy` ≠ 0 counts as activity.

## Structure

- Shared package `cpc_input_pkg`:
  - state enum `arb_state_t` {JOY, MOUSE, PEND_M, PEND_J};
  - mode constants `ARB_AUTO`, `ARB_JOY`, `ARB_MOUSE`;
  - bit-position constants for the fire and direction fields.
- One sub-module, `arb_idle_timer`: saturating counter with clear/enable and a `expired` output, parameterised by `CW` and `IDLE_CYCLES`.

## Test plan

- **Reset:** assert `reset_n` = 0 mid-run → `dout` = 0, `owner` = 0, `mouse_rst` = 1 on the next edge, asynchronously.
- **Mouse takeover:** auto mode, packet with dx = 8 → `owner` stays 0 until the `sel` falling edge, then `owner` = 1, `mouse_rst` = 0, and `dout` = `mouse_din` one cycle later.
- **Conflict:** mouse packet and `joy` = 7'h01 in the same cycle → state stays JOY; `dout` = 7'h01.
- **Idle timeout:** `IDLE_CYCLES` = 16, mouse owner with no packets → PEND_J after 16 cycles, JOY at the next boundary.
- **Mouse resumes:** mouse activity during PEND_J → back to MOUSE, counter cleared.
- **Merge mode:** with `MOUSE_ARB_MERGE_EN`, mouse owner and `joy` = 7'h10 → `dout[4]` = 1 and `owner` stays 1. Without the macro, the FSM goes to PEND_J.
